// File: rtl/dscrptr_cache_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : dscrptr_cache_rd_sched
// Purpose  : Round-robin read scheduler for the internal/external descriptor
//            cache. Picks the next eligible slot, issues a one-cycle cache
//            read, waits out the ECC RAM latency, then offers the descriptor
//            to DMATranCtrl with a req/ack handshake. The slot is held until
//            DMATranCtrl writes it back. A double-bit ECC error, a withdrawn
//            slot or a write-back timeout all release the slot early.
// Ports    : clock/reset       - single clock, synchronous active-high reset
//            dscrptrValid      - per-slot data-valid (internal descriptors)
//            extDscrptr        - per-slot external flag (always eligible)
//            eccDbErr          - cache double-bit error at end of read wait
//            dscrptrAck        - DMATranCtrl accepted the request
//            wrBack/wrBackNum  - write-back strobe and slot number
//            dscrptrRdAddr     - cache read address
//            rdEn              - one-cycle cache read enable
//            dscrptrReq/Num    - request to DMATranCtrl and its slot
//            busy              - scheduler not idle
//            dbErrPulse        - request dropped on ECC error
//            wbTimeoutPulse    - write-back timeout fired
// Revision : 1.0 - initial release
// ============================================================================
module dscrptr_cache_rd_sched #(
  parameter int NUM_OF_BDS       = 4,
  parameter int NUM_OF_BDS_WIDTH = 2,
  parameter int RD_LATENCY       = 2,
  parameter int WB_TIMEOUT       = 1024
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_OF_BDS-1:0]       dscrptrValid,
  input  logic [NUM_OF_BDS-1:0]       extDscrptr,
  input  logic                        eccDbErr,
  input  logic                        dscrptrAck,
  input  logic                        wrBack,
  input  logic [NUM_OF_BDS_WIDTH-1:0] wrBackNum,
  output logic [NUM_OF_BDS_WIDTH-1:0] dscrptrRdAddr,
  output logic                        rdEn,
  output logic                        dscrptrReq,
  output logic [NUM_OF_BDS_WIDTH-1:0] dscrptrReqNum,
  output logic                        busy,
  output logic                        dbErrPulse,
  output logic                        wbTimeoutPulse
);

  // Timeout counter only needs to reach WB_TIMEOUT-1.
  localparam int C_WB_CNT_W = (WB_TIMEOUT > 2) ? $clog2(WB_TIMEOUT) : 1;
  localparam logic [C_WB_CNT_W-1:0] C_WB_LAST =
    C_WB_CNT_W'((WB_TIMEOUT > 0) ? (WB_TIMEOUT - 1) : 0);
  localparam bit C_WB_EN = (WB_TIMEOUT != 0);
  localparam logic [3:0] C_RD_LOAD = 4'(RD_LATENCY - 1);

  // The search index is one bit wider than a slot number so rrPtr+k can be
  // formed without overflow before wrapping. Eligibility is zero-padded to the
  // full index range so any index value selects a defined bit.
  localparam int C_PAD_W = 2 ** (NUM_OF_BDS_WIDTH + 1);
  localparam logic [NUM_OF_BDS_WIDTH:0]   C_NUM       = (NUM_OF_BDS_WIDTH + 1)'(NUM_OF_BDS);
  localparam logic [NUM_OF_BDS_WIDTH-1:0] C_LAST_SLOT = NUM_OF_BDS_WIDTH'(NUM_OF_BDS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_REQ      = 3'd3,
    S_WB_WAIT  = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_nextState;
  logic [NUM_OF_BDS_WIDTH-1:0] r_rrPtr;
  logic [NUM_OF_BDS_WIDTH-1:0] w_nextRrPtr;
  logic [NUM_OF_BDS_WIDTH-1:0] r_slot;
  logic [NUM_OF_BDS_WIDTH-1:0] w_nextSlot;
  logic [NUM_OF_BDS_WIDTH-1:0] r_addr;
  logic [NUM_OF_BDS_WIDTH-1:0] w_nextAddr;
  logic [3:0]                  r_cnt;
  logic [3:0]                  w_nextCnt;
  logic [C_WB_CNT_W-1:0]       r_wbCnt;
  logic [C_WB_CNT_W-1:0]       w_nextWbCnt;
  logic                        r_dbErrPulse;
  logic                        w_setDbErr;
  logic                        r_wbTimeoutPulse;
  logic                        w_setWbTimeout;

  logic [C_PAD_W-1:0]          w_eligPad;
  logic [NUM_OF_BDS_WIDTH:0]   w_idx;
  logic                        w_hit;
  logic [NUM_OF_BDS_WIDTH-1:0] w_pick;
  logic                        w_slotElig;
  logic                        w_wbMatch;
  logic [NUM_OF_BDS_WIDTH-1:0] w_slotInc;

  // Eligibility and round-robin search starting at rrPtr.
  always_comb begin
    w_eligPad                   = '0;
    w_eligPad[NUM_OF_BDS-1:0]   = dscrptrValid | extDscrptr;
    w_hit                       = 1'b0;
    w_pick                      = '0;
    w_idx                       = '0;
    for (int k = 0; k < NUM_OF_BDS; k++) begin
      w_idx = {1'b0, r_rrPtr} + k[NUM_OF_BDS_WIDTH:0];
      if (w_idx >= C_NUM) begin
        w_idx = w_idx - C_NUM;
      end
      if (!w_hit && w_eligPad[w_idx]) begin
        w_hit  = 1'b1;
        w_pick = w_idx[NUM_OF_BDS_WIDTH-1:0];
      end
    end
  end

  assign w_slotElig = w_eligPad[{1'b0, r_slot}];
  assign w_wbMatch  = wrBack && (wrBackNum == r_slot);
  assign w_slotInc  = (r_slot == C_LAST_SLOT) ? '0 : (r_slot + NUM_OF_BDS_WIDTH'(1));

  // Next-state and datapath updates.
  always_comb begin
    w_nextState    = r_state;
    w_nextRrPtr    = r_rrPtr;
    w_nextSlot     = r_slot;
    w_nextAddr     = r_addr;
    w_nextCnt      = r_cnt;
    w_nextWbCnt    = r_wbCnt;
    w_setDbErr     = 1'b0;
    w_setWbTimeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          // Address is loaded here so it is already valid during RD_ISSUE.
          w_nextSlot  = w_pick;
          w_nextAddr  = w_pick;
          w_nextState = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        w_nextCnt   = C_RD_LOAD;
        w_nextState = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (r_cnt != 4'd0) begin
          if (!w_slotElig) begin
            w_nextState = S_IDLE;
          end else begin
            w_nextCnt = r_cnt - 4'd1;
          end
        end else if (eccDbErr) begin
          // Data has been read; the error report takes precedence over withdraw.
          w_setDbErr  = 1'b1;
          w_nextRrPtr = w_slotInc;
          w_nextState = S_IDLE;
        end else if (!w_slotElig) begin
          w_nextState = S_IDLE;
        end else begin
          w_nextState = S_REQ;
        end
      end
      S_REQ: begin
        if (dscrptrAck) begin
          if (w_wbMatch) begin
            w_nextRrPtr = w_slotInc;
            w_nextState = S_IDLE;
          end else begin
            w_nextWbCnt = '0;
            w_nextState = S_WB_WAIT;
          end
        end else if (!w_slotElig) begin
          w_nextState = S_IDLE;
        end
      end
      S_WB_WAIT: begin
        w_nextWbCnt = r_wbCnt + C_WB_CNT_W'(1);
        if (w_wbMatch) begin
          w_nextRrPtr = w_slotInc;
          w_nextState = S_IDLE;
        end else if (C_WB_EN && (r_wbCnt == C_WB_LAST)) begin
          w_setWbTimeout = 1'b1;
          w_nextRrPtr    = w_slotInc;
          w_nextState    = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_rrPtr          <= '0;
      r_slot           <= '0;
      r_addr           <= '0;
      r_cnt            <= '0;
      r_wbCnt          <= '0;
      r_dbErrPulse     <= 1'b0;
      r_wbTimeoutPulse <= 1'b0;
    end else begin
      r_state          <= w_nextState;
      r_rrPtr          <= w_nextRrPtr;
      r_slot           <= w_nextSlot;
      r_addr           <= w_nextAddr;
      r_cnt            <= w_nextCnt;
      r_wbCnt          <= w_nextWbCnt;
      r_dbErrPulse     <= w_setDbErr;
      r_wbTimeoutPulse <= w_setWbTimeout;
    end
  end

  // Outputs are forced low while reset is high, not only after the edge.
  assign dscrptrRdAddr  = reset ? '0 : r_addr;
  assign rdEn           = !reset && (r_state == S_RD_ISSUE);
  assign dscrptrReq     = !reset && (r_state == S_REQ);
  assign dscrptrReqNum  = reset ? '0 : r_slot;
  assign busy           = !reset && (r_state != S_IDLE);
  assign dbErrPulse     = !reset && r_dbErrPulse;
  assign wbTimeoutPulse = !reset && r_wbTimeoutPulse;

endmodule
`default_nettype wire

// File: tb/tb_dscrptr_cache_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_dscrptr_cache_rd_sched
// Purpose  : Directed bench for dscrptr_cache_rd_sched with an event
//            scoreboard (request starts, ECC-drop and timeout pulses).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dscrptr_cache_rd_sched;

  localparam int C_N  = 4;
  localparam int C_W  = 2;
  localparam int EV_REQ  = 1;
  localparam int EV_DBE  = 2;
  localparam int EV_WBTO = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [C_N-1:0] dscrptrValid = '0;
  logic [C_N-1:0] extDscrptr = '0;
  logic           eccDbErr = 1'b0;
  logic           dscrptrAck = 1'b0;
  logic           wrBack = 1'b0;
  logic [C_W-1:0] wrBackNum = '0;
  logic [C_W-1:0] dscrptrRdAddr;
  logic           rdEn;
  logic           dscrptrReq;
  logic [C_W-1:0] dscrptrReqNum;
  logic           busy;
  logic           dbErrPulse;
  logic           wbTimeoutPulse;

  int nVec = 0;
  int nErr = 0;
  int expQ[$];
  logic prevReq = 1'b0;

  dscrptr_cache_rd_sched #(
    .NUM_OF_BDS(C_N), .NUM_OF_BDS_WIDTH(C_W), .RD_LATENCY(2), .WB_TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset), .dscrptrValid(dscrptrValid),
    .extDscrptr(extDscrptr), .eccDbErr(eccDbErr), .dscrptrAck(dscrptrAck),
    .wrBack(wrBack), .wrBackNum(wrBackNum), .dscrptrRdAddr(dscrptrRdAddr),
    .rdEn(rdEn), .dscrptrReq(dscrptrReq), .dscrptrReqNum(dscrptrReqNum),
    .busy(busy), .dbErrPulse(dbErrPulse), .wbTimeoutPulse(wbTimeoutPulse)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nErr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every observed event must match the head of the expected queue.
  task automatic popEvent(input int kind, input int val);
    if (expQ.size() == 0) begin
      chk("unexpected_event", kind * 16 + val, 0);
    end else begin
      chk("scoreboard_event", kind * 16 + val, expQ.pop_front());
    end
  endtask

  always @(negedge clock) begin
    if (dscrptrReq && !prevReq) popEvent(EV_REQ, int'(dscrptrReqNum));
    if (dbErrPulse) popEvent(EV_DBE, 0);
    if (wbTimeoutPulse) popEvent(EV_WBTO, 0);
    prevReq = dscrptrReq;
  end

  task automatic expReq(input int slot);
    expQ.push_back(EV_REQ * 16 + slot);
  endtask

  task automatic waitReq(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      n++;
      if (dscrptrReq) return;
    end
    chk("req_wait_expired", 0, 1);
  endtask

  task automatic waitRdEn();
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (rdEn) return;
    end
    chk("rden_wait_expired", 0, 1);
  endtask

  function automatic int allOuts();
    return int'({rdEn, dscrptrReq, busy, dbErrPulse, wbTimeoutPulse,
                 dscrptrRdAddr, dscrptrReqNum});
  endfunction

  // One-cycle reset; new eligibility applied while reset is high.
  task automatic doReset(input logic [C_N-1:0] v, input logic [C_N-1:0] e);
    @(posedge clock); #1;
    reset = 1'b1;
    dscrptrValid = v;
    extDscrptr = e;
    @(negedge clock);
    chk("reset_outputs_zero", allOuts(), 0);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Wait for the request, ack at once, write back the next cycle.
  task automatic serve(input int slot, input logic [C_N-1:0] vAfter,
                       input logic [C_N-1:0] eAfter, input bit chkLat);
    int n;
    waitReq(n);
    if (chkLat) chk("req_latency", n, 4);
    chk("rd_addr_held", int'(dscrptrRdAddr), slot);
    dscrptrAck = 1'b1;
    @(negedge clock);
    chk("wb_wait_busy", int'(busy), 1);
    dscrptrAck = 1'b0;
    wrBack = 1'b1;
    wrBackNum = C_W'(slot);
    dscrptrValid = vAfter;
    extDscrptr = eAfter;
    @(negedge clock);
    wrBack = 1'b0;
    chk("idle_after_wb", int'(busy), 0);
  endtask

  initial begin
    int n;
    int hit;
    @(negedge clock);
    chk("reset_outputs_zero", allOuts(), 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Fairness / wrap: 0,1,2,3,0.
    expReq(0); expReq(1); expReq(2); expReq(3); expReq(0);
    @(negedge clock);
    dscrptrValid = 4'b1111;
    serve(0, 4'b1111, 4'b0000, 1'b0);
    serve(1, 4'b1111, 4'b0000, 1'b1);
    serve(2, 4'b1111, 4'b0000, 1'b1);
    serve(3, 4'b1111, 4'b0000, 1'b1);
    serve(0, 4'b0000, 4'b0000, 1'b1);

    // ECC double-bit error on slot 0, then slot 2, then slot 0.
    expQ.push_back(EV_DBE * 16);
    expReq(2); expReq(0);
    doReset(4'b0101, 4'b0000);
    waitRdEn();
    chk("ecc_rd_addr", int'(dscrptrRdAddr), 0);
    @(negedge clock);
    @(negedge clock);
    eccDbErr = 1'b1;
    @(negedge clock);
    eccDbErr = 1'b0;
    chk("dberr_pulse", int'(dbErrPulse), 1);
    chk("dberr_idle", int'(busy), 0);
    serve(2, 4'b0101, 4'b0000, 1'b1);
    serve(0, 4'b0000, 4'b0000, 1'b1);

    // External polling on slot 1, then withdraw in REQ.
    expReq(1); expReq(1); expReq(1);
    @(negedge clock);
    extDscrptr = 4'b0010;
    serve(1, 4'b0000, 4'b0010, 1'b0);
    serve(1, 4'b0000, 4'b0010, 1'b1);
    waitReq(n);
    chk("ext_req_latency", n, 4);
    extDscrptr = 4'b0000;
    @(negedge clock);
    chk("withdraw_req_low", int'(dscrptrReq), 0);
    chk("withdraw_idle", int'(busy), 0);

    // Write-back timeout on slot 1 while only slot 3 is written back.
    expReq(1); expQ.push_back(EV_WBTO * 16); expReq(2);
    @(negedge clock);
    dscrptrValid = 4'b0010;
    waitReq(n);
    dscrptrAck = 1'b1;
    @(negedge clock);
    dscrptrAck = 1'b0;
    wrBack = 1'b1;
    wrBackNum = 2'd3;
    hit = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (wbTimeoutPulse && hit == 0) hit = i;
    end
    chk("timeout_cycle", hit, 8);
    chk("timeout_idle", int'(busy), 0);
    wrBack = 1'b0;
    dscrptrValid = 4'b0110;   // rrPtr must now be 2, so slot 2 wins
    serve(2, 4'b0000, 4'b0000, 1'b1);

    // Ack and matching write-back in the same REQ cycle.
    expReq(3); expReq(0);
    @(negedge clock);
    dscrptrValid = 4'b1000;
    waitReq(n);
    dscrptrAck = 1'b1;
    wrBack = 1'b1;
    wrBackNum = 2'd3;
    @(negedge clock);
    chk("ack_wb_direct_idle", int'(busy), 0);
    dscrptrAck = 1'b0;
    wrBack = 1'b0;
    dscrptrValid = 4'b1001;   // advanced rrPtr (0) selects slot 0
    // Matching write-back on the timeout cycle: no pulse.
    waitReq(n);
    chk("sim_req_latency", n, 4);
    dscrptrAck = 1'b1;
    @(negedge clock);
    dscrptrAck = 1'b0;
    dscrptrValid = 4'b0000;
    for (int i = 0; i < 7; i++) @(negedge clock);
    wrBack = 1'b1;
    wrBackNum = 2'd0;
    @(negedge clock);
    wrBack = 1'b0;
    chk("wb_beats_timeout", int'(wbTimeoutPulse), 0);
    chk("wb_timeout_idle", int'(busy), 0);

    // Reset in the middle of REQ.
    expReq(2); expReq(0);
    @(negedge clock);
    dscrptrValid = 4'b0100;
    waitReq(n);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("midreq_reset_outputs", allOuts(), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midreq_reset_idle", int'(busy), 0);
    dscrptrValid = 4'b1111;
    serve(0, 4'b0000, 4'b0000, 1'b1);

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
